// File: rtl/udp_pkg.sv
// udp_pkg: shared definitions for the UDP transmit scheduler.
//   state_t      - scheduler FSM state encodings (8-bit, fixed values)
//   UDP_HDR_LEN  - UDP header length in bytes
//   UDP_MIN_LEN  - minimum UDP payload length that avoids Ethernet padding
package udp_pkg;

  typedef enum logic [7:0] {
    ST_IDLE = 8'h00,
    ST_GRNT = 8'h01,
    ST_SEND = 8'h02,
    ST_RELS = 8'h03,
    ST_ACKS = 8'h04,
    ST_FAIL = 8'h05
  } state_t;

  localparam int          UDP_HDR_LEN = 8;
  localparam logic [15:0] UDP_MIN_LEN = 16'h12;

endpackage

// File: rtl/udp_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   in  NCH   request vector
//   last  in  SELW  index of the most recently served channel
//   grant out SELW  first requesting index scanning last+1, last+2, ... mod NCH
//   valid out 1     at least one request is present
module rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] grant,
  output logic            valid
);

  int              idx;
  logic [NCH-1:0]  probe;

  // The scan starts one past the last winner, so the last winner is looked
  // at only after every other channel: this is what makes it fair.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    probe = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx   = (int'(last) + i) % NCH;
      probe = NCH'(1) << idx;
      if (!valid && ((req & probe) != '0)) begin
        valid = 1'b1;
        grant = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin scheduler sharing one udp_tx engine between
// NCH packet sources.
//   clk, rst          clock, asynchronous active-high reset
//   req               per-channel level request, held until own ack/err
//   ch_src_port       channel i source port at [16i+15:16i]
//   ch_det_port       channel i destination port, same packing
//   ch_data_len       channel i payload length, same packing
//   ack / err         one-cycle per-channel completion / failure pulses
//   udp_fs / udp_fd   frame start to udp_tx / frame done from udp_tx
//   src_port, det_port, data_len  latched fields for the granted channel
//   sel               granted channel index (payload FIFO mux select)
//   busy              high whenever the FSM is not idle
//
// Handshake with udp_tx: udp_fs rises on entering SEND and stays high until
// udp_fd is seen; udp_fs then falls and the scheduler waits for udp_fd to
// drop before acknowledging, so a new frame never starts while the engine
// still reports the previous one as done.
module udp_tx_sched
  import udp_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          SELW    = 2,
  parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] ch_src_port,
  input  logic [16*NCH-1:0] ch_det_port,
  input  logic [16*NCH-1:0] ch_data_len,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    err,
  output logic              udp_fs,
  input  logic              udp_fd,
  output logic [15:0]       src_port,
  output logic [15:0]       det_port,
  output logic [15:0]       data_len,
  output logic [SELW-1:0]   sel,
  output logic              busy
);

  state_t          state;
  state_t          state_nx;
  logic [SELW-1:0] last;
  logic [SELW-1:0] pick;
  logic            pick_valid;
  logic [19:0]     timer;
  logic [15:0]     pick_src;
  logic [15:0]     pick_det;
  logic [15:0]     pick_len;

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .req   (req),
    .last  (last),
    .grant (pick),
    .valid (pick_valid)
  );

  // Mux out the picked channel's fields; loop indices are constants so the
  // part-selects stay static.
  always_comb begin
    pick_src = '0;
    pick_det = '0;
    pick_len = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SELW'(i) == pick) begin
        pick_src = ch_src_port[16*i +: 16];
        pick_det = ch_det_port[16*i +: 16];
        pick_len = ch_data_len[16*i +: 16];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nx = ST_GRNT;
      // A zero length would leave udp_tx with no way to finish the frame.
      ST_GRNT: state_nx = (data_len == 16'h0000) ? ST_FAIL : ST_SEND;
      ST_SEND: begin
        if (udp_fd)                          state_nx = ST_RELS;
        else if (timer == TIMEOUT - 20'd1)   state_nx = ST_FAIL;
      end
      ST_RELS: if (!udp_fd) state_nx = ST_ACKS;
      ST_ACKS: state_nx = ST_IDLE;
      ST_FAIL: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Grant latches, round-robin pointer and SEND timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      src_port <= '0;
      det_port <= '0;
      data_len <= '0;
      last     <= SELW'(NCH - 1);
      timer    <= '0;
    end else begin
      if (state == ST_IDLE && pick_valid) begin
        sel      <= pick;
        src_port <= pick_src;
        det_port <= pick_det;
        data_len <= pick_len;
      end
      if (state == ST_ACKS || state == ST_FAIL) last <= sel;
      if (state == ST_SEND) timer <= timer + 20'd1;
      else                  timer <= '0;
    end
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    udp_fs = (state == ST_SEND);
    busy   = (state != ST_IDLE);
    ack    = (state == ST_ACKS) ? (NCH'(1) << sel) : '0;
    err    = (state == ST_FAIL) ? (NCH'(1) << sel) : '0;
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: directed self-checking bench for udp_tx_sched.
// Main instance uses the full timeout; a second instance with TIMEOUT=64
// exercises the abort path.
module tb_udp_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] ch_src_port = '0;
  logic [63:0] ch_det_port = '0;
  logic [63:0] ch_data_len = '0;
  logic [3:0]  ack, err;
  logic        udp_fs;
  logic        udp_fd = 1'b0;
  logic [15:0] src_port, det_port, data_len;
  logic [1:0]  sel;
  logic        busy;

  logic [3:0]  req_t = '0;
  logic [3:0]  ack_t, err_t;
  logic        udp_fs_t;
  logic        udp_fd_t = 1'b0;
  logic [15:0] src_port_t, det_port_t, data_len_t;
  logic [1:0]  sel_t;
  logic        busy_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] src_tab [4];
  logic [15:0] det_tab [4];
  logic [15:0] len_tab [4];
  logic [1:0]  exp_q [$];

  udp_tx_sched #(.NCH(4), .SELW(2), .TIMEOUT(20'hFFFFF)) dut (
    .clk(clk), .rst(rst), .req(req),
    .ch_src_port(ch_src_port), .ch_det_port(ch_det_port), .ch_data_len(ch_data_len),
    .ack(ack), .err(err), .udp_fs(udp_fs), .udp_fd(udp_fd),
    .src_port(src_port), .det_port(det_port), .data_len(data_len),
    .sel(sel), .busy(busy)
  );

  udp_tx_sched #(.NCH(4), .SELW(2), .TIMEOUT(20'd64)) dut_t (
    .clk(clk), .rst(rst), .req(req_t),
    .ch_src_port(ch_src_port), .ch_det_port(ch_det_port), .ch_data_len(ch_data_len),
    .ack(ack_t), .err(err_t), .udp_fs(udp_fs_t), .udp_fd(udp_fd_t),
    .src_port(src_port_t), .det_port(det_port_t), .data_len(data_len_t),
    .sel(sel_t), .busy(busy_t)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ch();
    for (int i = 0; i < 4; i++) begin
      ch_src_port[16*i +: 16] = src_tab[i];
      ch_det_port[16*i +: 16] = det_tab[i];
      ch_data_len[16*i +: 16] = len_tab[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    check("rst_fs", udp_fs, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_sel", sel, 0);
    check("rst_len", data_len, 0);
    check("rst_src", src_port, 0);
    rst = 1'b0;
  endtask

  // One full transaction on the main instance, starting in IDLE with req set.
  // fd_wait: extra SEND cycles before the one-cycle udp_fd pulse.
  task automatic serve(input int fd_wait, input bit clear_req, input bit poke);
    logic [1:0] e;
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
    e = exp_q.pop_front();
    tick();
    check("grnt_busy", busy, 1);
    check("grnt_fs", udp_fs, 0);
    check("grnt_sel", sel, e);
    tick();
    check("send_fs", udp_fs, 1);
    check("send_src", src_port, src_tab[e]);
    check("send_det", det_port, det_tab[e]);
    check("send_len", data_len, len_tab[e]);
    if (poke) ch_data_len[16*e +: 16] = 16'hDEAD;
    repeat (fd_wait) tick();
    check("hold_fs", udp_fs, 1);
    check("hold_len", data_len, len_tab[e]);
    udp_fd = 1'b1;
    tick();
    udp_fd = 1'b0;
    check("rels_fs", udp_fs, 0);
    check("rels_ack", ack, 0);
    tick();
    check("ack", ack, 32'(1) << e);
    check("ack_err", err, 0);
    check("ack_len", data_len, len_tab[e]);
    if (clear_req) req[e] = 1'b0;
    tick();
    check("ack_clr", ack, 0);
    check("idle_busy", busy, 0);
    if (poke) set_ch();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4; i++) begin
      src_tab[i] = 16'h1F90 + 16'(i) * 16'h0100;
      det_tab[i] = src_tab[i] + 16'h0001;
    end
    len_tab[0] = 16'd100;
    len_tab[1] = 16'd64;
    len_tab[2] = 16'd40;
    len_tab[3] = 16'd1500;
    set_ch();

    // Reset state, then single request on ch0 with an fd after 108 cycles;
    // ch0 length is disturbed mid-SEND and must not reach data_len.
    do_reset();
    req = 4'b0001;
    exp_q.push_back(2'd0);
    serve(107, 1'b1, 1'b1);

    // Contention from reset: ch1 then ch3, then a held 4'b1111.
    do_reset();
    req = 4'b1010;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    serve(3, 1'b1, 1'b0);
    serve(3, 1'b1, 1'b0);
    check("cont_req_empty", req, 0);
    req = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int k = 0; k < 5; k++) serve(2, 1'b0, 1'b0);
    req = 4'b0000;

    // Zero length on ch2 (last is 0, so ch2 wins): GRNT -> FAIL.
    len_tab[2] = 16'd0;
    set_ch();
    req = 4'b0100;
    tick();
    check("zl_sel", sel, 2);
    check("zl_fs_grnt", udp_fs, 0);
    tick();
    check("zl_fs_fail", udp_fs, 0);
    check("zl_err", err, 4'b0100);
    check("zl_ack", ack, 0);
    req = 4'b0000;
    tick();
    check("zl_err_clr", err, 0);
    check("zl_busy", busy, 0);
    len_tab[2] = 16'd40;
    set_ch();
    // Next grant starts after ch2, so ch3 beats ch0.
    req = 4'b1001;
    exp_q.push_back(2'd3);
    serve(2, 1'b1, 1'b0);
    req = 4'b0000;

    // Timeout on the TIMEOUT=64 instance with fd stuck low.
    req_t = 4'b0001;
    tick();
    check("to_busy", busy_t, 1);
    tick();
    check("to_fs", udp_fs_t, 1);
    n = 0;
    while (udp_fs_t && n < 200) begin
      n++;
      tick();
    end
    check("to_fs_cycles", n, 64);
    check("to_err", err_t, 4'b0001);
    check("to_ack", ack_t, 0);
    req_t = 4'b0000;
    tick();
    check("to_busy_after", busy_t, 0);
    check("to_err_clr", err_t, 0);

    // Reset asserted mid-SEND.
    req = 4'b0001;
    tick();
    tick();
    repeat (5) tick();
    check("mid_fs", udp_fs, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_fs", udp_fs, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_err", err, 0);
    req = 4'b0000;
    tick();
    rst = 1'b0;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_len", data_len, 0);
    req = 4'b0100;
    exp_q.push_back(2'd2);
    serve(4, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
